// File: rtl/ifetch_unit.sv
// Instruction fetch unit: program counter, instruction register and a single-outstanding memory read FSM.
// Latency: ir_load at cycle N with imem_ack at N+1 gives ir and the ir_done pulse at N+2; pc updates one cycle after pc_write.
// Backpressure: one fetch in flight at a time, ir_load is ignored while busy or faulted, and a missing ack times out into ERR.
module ifetch_unit #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_rst,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic          ir_load,
  input  logic [15:0]   imm,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] ir,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic          busy,
  output logic          ir_done,
  output logic          fetch_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [CW-1:0]   wait_cnt;
  logic [AW-1:0]   pc_next;
  logic [AW+15:0]  imm_sx_wide;
  logic [AW+15:0]  imm_zx_wide;
  logic [AW-1:0]   imm_sx;
  logic [AW-1:0]   imm_zx;

  // Widen imm before cutting to AW so any AW (smaller or larger than 16) works.
  assign imm_sx_wide = {{AW{imm[15]}}, imm};
  assign imm_zx_wide = {{AW{1'b0}}, imm};
  assign imm_sx      = imm_sx_wide[AW-1:0];
  assign imm_zx      = imm_zx_wide[AW-1:0];

  assign opcode = ir[31:28];
  assign mm     = ir[27:24];
  assign busy   = (state == REQ);

  // Next PC: sequential, relative branch (from pc+1) or absolute target; wraps modulo 2^AW.
  always_comb begin
    pc_next = pc + AW'(1);
    if (pc_sel) begin
      if (br_sel) pc_next = imm_zx;
      else        pc_next = pc + AW'(1) + imm_sx;
    end
  end

  // PC register: pc_rst beats pc_write; updates are honoured in every FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (pc_rst) begin
      pc <= '0;
    end else if (pc_write) begin
      pc <= pc_next;
    end
  end

  // Fetch FSM: latch address on start, capture data on ack, abort on pc_rst, fault on timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ir        <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      ir_done   <= 1'b0;
      fetch_err <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      ir_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ir_load) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            // A same-cycle pc_rst means the fetch targets the cleared PC.
            imem_addr <= pc_rst ? '0 : pc;
            wait_cnt  <= '0;
          end
        end
        REQ: begin
          if (pc_rst) begin
            // Abort wins over a coincident ack: data is dropped, ir untouched.
            state    <= IDLE;
            imem_req <= 1'b0;
            wait_cnt <= '0;
          end else if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            ir       <= imem_rdata;
            ir_done  <= 1'b1;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            // TIMEOUT REQ cycles with no ack: load a NOOP and park in ERR.
            state     <= ERR;
            imem_req  <= 1'b0;
            ir        <= '0;
            fetch_err <= 1'b1;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ERR: begin
          if (pc_rst) begin
            state     <= IDLE;
            fetch_err <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios with inline checks plus a fetch scoreboard.
// Inputs change #1 after the rising edge; outputs are sampled there too, and ir_done on the falling edge.
// Expected instruction words are queued when an ack is driven and popped when ir_done appears.
module tb_ifetch_unit;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;

  logic          clk;
  logic          rst;
  logic          pc_rst;
  logic          pc_write;
  logic          pc_sel;
  logic          br_sel;
  logic          ir_load;
  logic [15:0]   imm;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic [AW-1:0] pc;
  logic [DW-1:0] ir;
  logic [3:0]    opcode;
  logic [3:0]    mm;
  logic          busy;
  logic          ir_done;
  logic          fetch_err;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  ifetch_unit #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
    .br_sel(br_sel), .ir_load(ir_load), .imm(imm), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc),
    .ir(ir), .opcode(opcode), .mm(mm), .busy(busy), .ir_done(ir_done), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every ir_done must match the oldest queued word.
  always @(negedge clk) begin
    if (!rst && ir_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ir_done: ir=%h, no fetch expected", ir);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (ir !== e) begin
          errors++;
          $display("FAIL sb_ir: got %h expected %h", ir, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0;
    imm = '0; imem_ack = 0; imem_rdata = '0;
  endtask

  task automatic set_pc(input logic [15:0] v);
    pc_write = 1; pc_sel = 1; br_sel = 1; imm = v;
    tick();
    pc_write = 0; pc_sel = 0; br_sel = 0; imm = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #3;
    checks++;
    if ({pc, ir, imem_req, imem_addr, busy, ir_done, fetch_err} !== '0) begin
      errors++;
      $display("FAIL reset_state: pc=%h ir=%h req=%b addr=%h busy=%b done=%b err=%b, required all zero",
               pc, ir, imem_req, imem_addr, busy, ir_done, fetch_err);
    end
    tick(2);
    rst = 0;
    tick();
  endtask

  // ir_load at N, ack at N+3, result at N+4, fetch from address 0 after reset.
  task automatic test_basic_fetch();
    ir_load = 1;
    tick();
    ir_load = 0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_req: req=%b addr=%h busy=%b, required 1 0000 1", imem_req, imem_addr, busy);
    end
    tick(2);
    checks++;
    if (imem_req !== 1'b1 || ir_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_wait: req=%b done=%b, required 1 0", imem_req, ir_done);
    end
    imem_ack = 1; imem_rdata = 32'h8100_0005;
    exp_q.push_back(32'h8100_0005);
    tick();
    imem_ack = 0; imem_rdata = '0;
    checks++;
    if (ir !== 32'h8100_0005 || opcode !== 4'h8 || mm !== 4'h1 || ir_done !== 1'b1 ||
        imem_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: ir=%h op=%h mm=%h done=%b req=%b busy=%b, required 81000005 8 1 1 0 0",
               ir, opcode, mm, ir_done, imem_req, busy);
    end
    tick();
    checks++;
    if (ir_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: ir_done=%b, required 0", ir_done);
    end
  endtask

  // Ack in the first REQ cycle, then a stray ack while idle.
  task automatic test_min_latency();
    ir_load = 1;
    tick();
    ir_load = 0;
    imem_ack = 1; imem_rdata = 32'h3C5A_1234;
    exp_q.push_back(32'h3C5A_1234);
    tick();
    imem_ack = 0;
    checks++;
    if (ir !== 32'h3C5A_1234 || ir_done !== 1'b1 || opcode !== 4'h3 || mm !== 4'hC) begin
      errors++;
      $display("FAIL min_latency: ir=%h done=%b op=%h mm=%h, required 3c5a1234 1 3 c", ir, ir_done, opcode, mm);
    end
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 0; imem_rdata = '0;
    checks++;
    if (ir !== 32'h3C5A_1234 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack_ignored: ir=%h req=%b, required 3c5a1234 0", ir, imem_req);
    end
  endtask

  task automatic test_branch();
    set_pc(16'h0010);
    pc_write = 1; pc_sel = 1; br_sel = 0; imm = 16'hFFFC;
    tick();
    checks++;
    if (pc !== 16'h000D) begin
      errors++;
      $display("FAIL branch_relative: pc=%h required 000d", pc);
    end
    br_sel = 1; imm = 16'h0200;
    tick();
    checks++;
    if (pc !== 16'h0200) begin
      errors++;
      $display("FAIL branch_absolute: pc=%h required 0200", pc);
    end
    pc_sel = 0; br_sel = 0; imm = '0;
    tick();
    pc_write = 0;
    checks++;
    if (pc !== 16'h0201) begin
      errors++;
      $display("FAIL pc_sequential: pc=%h required 0201", pc);
    end
  endtask

  task automatic test_wrap();
    set_pc(16'hFFFF);
    pc_write = 1; pc_sel = 0;
    tick();
    pc_write = 0;
    checks++;
    if (pc !== 16'h0000) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h required 0000", pc);
    end
    set_pc(16'h0005);
    pc_write = 1; pc_rst = 1;
    tick();
    pc_write = 0; pc_rst = 0;
    checks++;
    if (pc !== 16'h0000) begin
      errors++;
      $display("FAIL pc_rst_priority: pc=%h required 0000", pc);
    end
  endtask

  task automatic test_timeout();
    ir_load = 1;
    tick();
    ir_load = 0;
    tick(TIMEOUT - 1);
    checks++;
    if (busy !== 1'b1 || fetch_err !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: busy=%b err=%b req=%b, required 1 0 1", busy, fetch_err, imem_req);
    end
    tick();
    checks++;
    if (fetch_err !== 1'b1 || ir !== '0 || imem_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fault: err=%b ir=%h req=%b busy=%b, required 1 0 0 0", fetch_err, ir, imem_req, busy);
    end
    ir_load = 1; imem_ack = 1; imem_rdata = 32'h1111_2222;
    tick();
    ir_load = 0; imem_ack = 0; imem_rdata = '0;
    tick();
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || ir !== '0) begin
      errors++;
      $display("FAIL err_sticky: err=%b req=%b ir=%h, required 1 0 0", fetch_err, imem_req, ir);
    end
    pc_rst = 1;
    tick();
    pc_rst = 0;
    checks++;
    if (fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b required 0", fetch_err);
    end
    ir_load = 1;
    tick();
    ir_load = 0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL err_to_idle: req=%b addr=%h, required 1 0000", imem_req, imem_addr);
    end
    imem_ack = 1; imem_rdata = 32'h7000_00AA;
    exp_q.push_back(32'h7000_00AA);
    tick();
    imem_ack = 0; imem_rdata = '0;
  endtask

  task automatic test_abort();
    set_pc(16'h0007);
    ir_load = 1;
    tick();
    checks++;
    if (imem_addr !== 16'h0007 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL abort_req: addr=%h req=%b, required 0007 1", imem_addr, imem_req);
    end
    tick();
    ir_load = 0;
    pc_rst = 1; imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    pc_rst = 0; imem_ack = 0; imem_rdata = '0;
    checks++;
    if (imem_req !== 1'b0 || busy !== 1'b0 || ir !== 32'h7000_00AA || pc !== 16'h0000 || ir_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_result: req=%b busy=%b ir=%h pc=%h done=%b, required 0 0 700000aa 0000 0",
               imem_req, busy, ir, pc, ir_done);
    end
    tick(3);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_extra_req: req=%b required 0", imem_req);
    end
    set_pc(16'h0033);
    pc_rst = 1; ir_load = 1;
    tick();
    pc_rst = 0; ir_load = 0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || pc !== 16'h0000) begin
      errors++;
      $display("FAIL rst_with_load: req=%b addr=%h pc=%h, required 1 0000 0000", imem_req, imem_addr, pc);
    end
    imem_ack = 1; imem_rdata = 32'h0102_0304;
    exp_q.push_back(32'h0102_0304);
    tick();
    imem_ack = 0; imem_rdata = '0;
  endtask

  task automatic test_pc_write_during_req();
    set_pc(16'h0004);
    ir_load = 1;
    tick();
    ir_load = 0;
    pc_write = 1; pc_sel = 0;
    tick();
    pc_write = 0;
    checks++;
    if (pc !== 16'h0005 || imem_addr !== 16'h0004 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL pcw_in_req: pc=%h addr=%h req=%b, required 0005 0004 1", pc, imem_addr, imem_req);
    end
    tick();
    checks++;
    if (imem_addr !== 16'h0004) begin
      errors++;
      $display("FAIL pcw_addr_hold: addr=%h required 0004", imem_addr);
    end
    imem_ack = 1; imem_rdata = 32'hF0E0_D0C0;
    exp_q.push_back(32'hF0E0_D0C0);
    tick();
    imem_ack = 0; imem_rdata = '0;
    checks++;
    if (ir !== 32'hF0E0_D0C0 || pc !== 16'h0005) begin
      errors++;
      $display("FAIL pcw_result: ir=%h pc=%h, required f0e0d0c0 0005", ir, pc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_min_latency();
    test_branch();
    test_wrap();
    test_timeout();
    test_abort();
    test_pc_write_during_req();
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d fetches never completed, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter AW, default 16, meaning PC / instruction-memory address width.
REQ-002 Parameter DW, default 32, meaning instruction word width.
REQ-003 Parameter TIMEOUT, default 15, meaning max wait cycles for imem_ack before fault.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 pc_rst  in  1  synchronous PC clear, driven by the control FSM.
REQ-007 pc_write  in  1  PC update strobe.
REQ-008 pc_sel  in  1  0 = sequential (pc+1); 1 = branch target.
REQ-009 br_sel  in  1  0 = relative target; 1 = absolute target.
REQ-010 ir_load  in  1  start-fetch strobe.
REQ-011 imm  in  16  branch offset (relative) or address (absolute).
REQ-012 imem_req  out  1  memory read request, level, registered.
REQ-013 imem_addr  out  AW  address latched at request start.
REQ-014 imem_ack  in  1  memory read data valid, single-cycle pulse.
REQ-015 imem_rdata  in  DW  instruction word, sampled when imem_ack=1.
REQ-016 pc  out  AW  program counter.
REQ-017 ir  out  DW  instruction register.
REQ-018 opcode  out  4  ir[31:28], combinational; mm  out  4  ir[27:24], combinational.
REQ-019 busy  out  1  high in REQ state; ir_done  out  1  one-cycle pulse when ir is updated; fetch_err  out  1  sticky fault flag.

Function
REQ-020 FSM states: IDLE, REQ, ERR.
REQ-021 IDLE + ir_load=1 -> REQ next cycle; imem_req=1 and imem_addr=pc-at-ir_load-cycle from that cycle on.
REQ-022 REQ + imem_ack=1 -> ir<=imem_rdata, ir_done=1 for one cycle, imem_req=0, state IDLE, all effective the cycle after the ack.
REQ-023 Minimum latency: ir_load at cycle N, ack at N+1 -> ir valid and ir_done at N+2.
REQ-024 Wait counter clears on REQ entry and increments each REQ cycle without ack; when TIMEOUT cycles elapse without ack -> state ERR, ir<=0 (NOOP), fetch_err=1, imem_req=0.
REQ-025 ERR is left only via pc_rst or rst -> IDLE; fetch_err clears only on those events.
REQ-026 ir_load while busy or in ERR: ignored. imem_ack while in IDLE or ERR: ignored, ir unchanged.
REQ-027 pc_write=1 and pc_sel=0: pc<=pc+1.
REQ-028 pc_write=1, pc_sel=1, br_sel=0: pc<=pc+1+sign-extend(imm).
REQ-029 pc_write=1, pc_sel=1, br_sel=1: pc<=imm zero-extended or truncated to AW.
REQ-030 All PC arithmetic is modulo 2^AW; no overflow flag.
REQ-031 pc_write is honoured in every state; imem_addr is not affected during an in-flight REQ.
REQ-032 pc_rst=1: pc<=0 and overrides a simultaneous pc_write.
REQ-033 pc_rst in REQ aborts the fetch: imem_req=0 next cycle, state IDLE, ir unchanged, no ir_done.
REQ-034 pc_rst and ir_load in the same IDLE cycle: the fetch starts with imem_addr=0.
REQ-035 imem_ack and pc_rst in the same REQ cycle: abort wins, rdata discarded.

Reset
REQ-036 rst=1 forces, asynchronously: state IDLE, pc=0, ir=0, imem_req=0, imem_addr=0, busy=0, ir_done=0, fetch_err=0, wait counter=0.
REQ-037 First ir_load after rst deassertion fetches address 0.

Verification
REQ-038 rst then ir_load at N, ack at N+3 with rdata=32'h8100_0005 -> imem_addr=0 during REQ, ir=32'h8100_0005, opcode=8, mm=1, ir_done pulse at N+4.
REQ-039 pc=16'h0010, pc_write, pc_sel=1, br_sel=0, imm=16'hFFFC -> pc=16'h000D; then br_sel=1, imm=16'h0200 -> pc=16'h0200.
REQ-040 pc=16'hFFFF, pc_write, pc_sel=0 -> pc=16'h0000.
REQ-041 ir_load with no ack for 15 cycles -> fetch_err=1, ir=0, imem_req=0; then pc_rst -> fetch_err=0, state IDLE.
REQ-042 pc_rst asserted in the same cycle as ack during REQ -> ir unchanged, no ir_done, pc=0; a second ir_load issued during busy produces no additional request.
REQ-043 pc_write during REQ with imem_addr=16'h0004 -> pc advances to 16'h0005, imem_addr stays 16'h0004 until ack.
